// File: rtl/display_pkg.sv
// display_pkg: shared display constants, anode polarity and digit-index width helper
package display_pkg;

    localparam int NDIG_DEF = 8;

    // Anodes and segments are active-low across the display path
    localparam bit SEG_ACTIVE_LOW = 1'b1;
    localparam logic AN_ON = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [15:0] AN_OFF = {16{~AN_ON}};

    function automatic int DIGW(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk into one enabled tick every DIV cycles, holding while disabled
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;

    assign tick    = en && presc_q == PW'(DIV - 1);
    assign presc_d = tick ? '0 : (en ? presc_q + 1'b1 : presc_q);

    // Prescaler counter, wraps on tick and freezes when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: double-buffered multi-digit hex scanner feeding hex7seg with anode drive
module hex_scan_driver
    import display_pkg::*;
#(
    parameter int NDIG     = NDIG_DEF,
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic [4*NDIG-1:0]       value_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output logic [3:0]              hex_o,
    output logic [NDIG-1:0]         an_o,
    output logic [DIGW(NDIG)-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int DW = DIGW(NDIG);
    localparam logic [DW-1:0] LAST = DW'(NDIG - 1);

    logic              tick, wrap, blank;
    logic [DW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] disp_q, disp_d, shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [NDIG:0]     uz;
    logic [NDIG-1:0]   an_d;
    logic [3:0]        hex_d;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en_i),
        .tick (tick)
    );

    assign wrap      = tick && idx_q == LAST;
    assign pending_o = pending_q;

    // Digit advance and frame-boundary swap; a load on the boundary edge stays pending
    always_comb begin
        idx_d     = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        shadow_d  = load_i ? value_i : shadow_q;
        pending_d = load_i || (pending_q && !wrap);
    end

    // Output decode from next-state so outputs move on the same edge as idx
    always_comb begin
        uz       = '0;
        uz[NDIG] = 1'b1;
        hex_d    = '0;
        blank    = 1'b0;
        an_d     = AN_OFF[NDIG-1:0];
        for (int k = NDIG - 1; k >= 0; k--) uz[k] = uz[k+1] && disp_d[4*k +: 4] == 4'h0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_d == DW'(k)) begin
                hex_d = disp_d[4*k +: 4];
                blank = BLANK_LZ != 0 && k != 0 && uz[k];
            end
        end
        if (en_i && !blank) an_d[idx_d] = AN_ON;
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= LAST;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            hex_o     <= '0;
            an_o      <= AN_OFF[NDIG-1:0];
            dig_o     <= LAST;
            frame_o   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            hex_o     <= hex_d;
            an_o      <= an_d;
            dig_o     <= idx_d;
            frame_o   <= wrap;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed table and sequence checks of the hex scan driver
module tb_hex_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic        pending_o, frame_o;
    logic [3:0]  hex_o, an_o;
    logic [1:0]  dig_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [3:0]  hex;
        logic [1:0]  dig;
        logic        fr;
        logic        pd;
    } vec_t;

    vec_t tbl [27];

    hex_scan_driver #(.NDIG(4), .DIV(3), .BLANK_LZ(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .value_i  (value_i),
        .load_i   (load_i),
        .pending_o(pending_o),
        .hex_o    (hex_o),
        .an_o     (an_o),
        .dig_o    (dig_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] val);
        @(negedge clk);
        en_i    = en;
        load_i  = ld;
        value_i = val;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] an, input logic [3:0] hex,
                           input logic [1:0] dig, input logic fr, input logic pd);
        chk({nm, " an"}, 32'(an_o), 32'(an));
        chk({nm, " hex"}, 32'(hex_o), 32'(hex));
        chk({nm, " dig"}, 32'(dig_o), 32'(dig));
        chk({nm, " frame"}, 32'(frame_o), 32'(fr));
        chk({nm, " pending"}, 32'(pending_o), 32'(pd));
    endtask

    task automatic wait_frame(input string nm);
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b0, 16'h0);
            n++;
        end while (!frame_o && n < 20);
        chk({nm, " frame seen"}, 32'(frame_o), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h0, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0A5F, 4'b1111, 4'h0, 2'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd2, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd2, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd2, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'hF, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 16'h0000, 4'b1101, 4'h5, 2'd1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 16'h0000, 4'b1101, 4'h5, 2'd1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 16'h0000, 4'b1101, 4'h5, 2'd1, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 16'h0000, 4'b1011, 4'hA, 2'd2, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 16'h0000, 4'b1011, 4'hA, 2'd2, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 16'h0000, 4'b1011, 4'hA, 2'd2, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'hF, 2'd0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].en, tbl[i].ld, tbl[i].val);
            chk_out($sformatf("vec%0d", i), tbl[i].an, tbl[i].hex, tbl[i].dig, tbl[i].fr, tbl[i].pd);
        end

        step(1'b1, 1'b1, 16'h1234);
        step(1'b1, 1'b1, 16'h5678);
        chk("double load pending", 32'(pending_o), 32'd1);
        wait_frame("double load");
        chk_out("double load d0", 4'b1110, 4'h8, 2'd0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 16'h0);
        chk_out("double load d1", 4'b1101, 4'h7, 2'd1, 1'b0, 1'b0);

        wait_frame("boundary setup");
        step(1'b1, 1'b1, 16'h1119);
        repeat (10) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'hABCD);
        chk_out("boundary load", 4'b1110, 4'h9, 2'd0, 1'b1, 1'b1);
        wait_frame("boundary next");
        chk_out("boundary next", 4'b1110, 4'hD, 2'd0, 1'b1, 1'b0);

        repeat (4) step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0);
            chk($sformatf("disabled%0d an", i), 32'(an_o), 32'hF);
            chk($sformatf("disabled%0d dig", i), 32'(dig_o), 32'd1);
        end
        step(1'b1, 1'b0, 16'h0);
        chk_out("resume held", 4'b1101, 4'hC, 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0);
        chk_out("resume tick", 4'b1011, 4'hB, 2'd2, 1'b0, 1'b0);

        step(1'b1, 1'b1, 16'h5555);
        chk("pre-reset pending", 32'(pending_o), 32'd1);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        en_i    = 1'b0;
        load_i  = 1'b0;
        #1;
        chk_out("async reset", 4'b1111, 4'h0, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0, 16'h0);
        chk_out("after reset", 4'b1110, 4'h0, 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
